// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache request arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  typedef logic [1:0] req_vec_t;

endpackage

// File: rtl/cache_arb_rr.sv
// Combinational two-way round-robin picker: one-hot grant plus grant id.
module cache_arb_rr
  import cache_arb_pkg::*;
(
  input  req_vec_t req_valid,
  input  logic     last_grant,
  output req_vec_t grant,
  output logic     grant_id
);

  // Under contention the requester not granted last wins.
  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    case (req_valid)
      2'b01: begin
        grant    = 2'b01;
        grant_id = 1'b0;
      end
      2'b10: begin
        grant    = 2'b10;
        grant_id = 1'b1;
      end
      2'b11: begin
        if (last_grant) begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end else begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
      end
      default: begin
        grant    = 2'b00;
        grant_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Two-requester front end for the cache engine: arbitrate, issue, wait, respond.
// Optional per-requester grant and abort counters under CACHE_ARB_STATS_EN.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W  = 48,
  parameter int OP_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][OP_W-1:0] req_op,
  output logic                 eng_valid,
  output logic [ADDR_W-1:0]    eng_addr,
  output logic [OP_W-1:0]      eng_op,
  input  logic                 eng_done,
  output logic [1:0]           rsp_valid,
  output logic                 rsp_err,
  output logic                 proto_err,
`ifdef CACHE_ARB_STATS_EN
  output logic [11:0]          grant_cnt0,
  output logic [11:0]          grant_cnt1,
  output logic [11:0]          abort_cnt,
`endif
  output logic                 busy
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] WD_MAX  = 16'(TIMEOUT);

  arb_state_t          state_r;
  logic                owner_r;
  logic                last_grant_r;
  logic                ready_en_r;
  logic [15:0]         wd_cnt_r;
  logic                eng_valid_r;
  logic [ADDR_W-1:0]   eng_addr_r;
  logic [OP_W-1:0]     eng_op_r;
  logic [1:0]          rsp_valid_r;
  logic                rsp_err_r;
  logic                proto_err_r;

  req_vec_t            grant_s;
  logic                grant_id_s;
  logic [1:0]          req_ready_s;
  logic                hs_s;
  logic                in_op_ok_s;
  logic                abort_s;

  cache_arb_rr u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_id   (grant_id_s)
  );

  // ready_en_r keeps req_ready low while reset is held and for the first cycle after it.
  assign req_ready_s = (state_r == ST_IDLE && ready_en_r) ? grant_s : 2'b00;
  assign hs_s        = |(req_valid & req_ready_s);
  assign in_op_ok_s  = (req_op[grant_id_s] == OP_W'(OP_READ)) ||
                       (req_op[grant_id_s] == OP_W'(OP_WRITE));
  assign abort_s     = (state_r == ST_WAIT) && !eng_done && (wd_cnt_r >= WD_LAST);

  // Main FSM with latched request, watchdog and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      ready_en_r   <= 1'b0;
      wd_cnt_r     <= 16'd0;
      eng_valid_r  <= 1'b0;
      eng_addr_r   <= '0;
      eng_op_r     <= '0;
      rsp_valid_r  <= 2'b00;
      rsp_err_r    <= 1'b0;
      proto_err_r  <= 1'b0;
    end else begin
      ready_en_r  <= 1'b1;
      eng_valid_r <= 1'b0;
      rsp_valid_r <= 2'b00;
      if (eng_done && state_r != ST_WAIT) begin
        proto_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            eng_addr_r   <= req_addr[grant_id_s];
            eng_op_r     <= req_op[grant_id_s];
            owner_r      <= grant_id_s;
            last_grant_r <= grant_id_s;
            eng_valid_r  <= in_op_ok_s;
            state_r      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt_r <= 16'd0;
          // eng_valid_r is high here exactly when the latched op was legal.
          if (eng_valid_r) begin
            state_r <= ST_WAIT;
          end else begin
            rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
            rsp_err_r   <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
            rsp_err_r   <= 1'b0;
            state_r     <= ST_RESP;
          end else if (abort_s) begin
            wd_cnt_r    <= WD_MAX;
            rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
            rsp_err_r   <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
          end
        end
        ST_RESP: begin
          rsp_err_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  logic [11:0] grant_cnt0_r;
  logic [11:0] grant_cnt1_r;
  logic [11:0] abort_cnt_r;

  // Saturating grant and watchdog-abort counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0_r <= 12'd0;
      grant_cnt1_r <= 12'd0;
      abort_cnt_r  <= 12'd0;
    end else begin
      if (hs_s && !grant_id_s && grant_cnt0_r != 12'hFFF) begin
        grant_cnt0_r <= grant_cnt0_r + 12'd1;
      end
      if (hs_s && grant_id_s && grant_cnt1_r != 12'hFFF) begin
        grant_cnt1_r <= grant_cnt1_r + 12'd1;
      end
      if (abort_s && abort_cnt_r != 12'hFFF) begin
        abort_cnt_r <= abort_cnt_r + 12'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_r;
  assign grant_cnt1 = grant_cnt1_r;
  assign abort_cnt  = abort_cnt_r;
`endif

  assign req_ready = req_ready_s;
  assign eng_valid = eng_valid_r;
  assign eng_addr  = eng_addr_r;
  assign eng_op    = eng_op_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign proto_err = proto_err_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter with a transaction-level reference model.
module tb_cache_req_arbiter;

  localparam int AW = 48;
  localparam int OW = 8;
  localparam int T  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][OW-1:0]  req_op;
  logic                eng_valid;
  logic [AW-1:0]       eng_addr;
  logic [OW-1:0]       eng_op;
  logic                eng_done;
  logic [1:0]          rsp_valid;
  logic                rsp_err;
  logic                proto_err;
  logic                busy;
`ifdef CACHE_ARB_STATS_EN
  logic [11:0]         grant_cnt0;
  logic [11:0]         grant_cnt1;
  logic [11:0]         abort_cnt;
`endif

  cache_req_arbiter #(.ADDR_W(AW), .OP_W(OW), .TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_op    (req_op),
    .eng_valid (eng_valid),
    .eng_addr  (eng_addr),
    .eng_op    (eng_op),
    .eng_done  (eng_done),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .proto_err (proto_err),
`ifdef CACHE_ARB_STATS_EN
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
    .abort_cnt (abort_cnt),
`endif
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending requests, last granted requester, counters.
  logic          pv[2];
  logic [AW-1:0] pa[2];
  logic [OW-1:0] po[2];
  int            last_m;
  int            gcnt_m[2];
  int            abort_m;
  int            rsp_seen[2];

  always @(negedge clk) begin
    if (rsp_valid[0] === 1'b1) rsp_seen[0]++;
    if (rsp_valid[1] === 1'b1) rsp_seen[1]++;
  end

  task automatic model_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    last_m = 1; gcnt_m[0] = 0; gcnt_m[1] = 0; abort_m = 0;
  endtask

  // One arbitrated operation; d = engine latency after eng_valid (d > T means never).
  // Entered and left at the start of an IDLE cycle.
  task automatic do_txn(input int d);
    int            winner, resp_k;
    logic          ok, exp_err, done_ok;
    logic [1:0]    oh;
    logic [AW-1:0] exp_addr;
    logic [OW-1:0] exp_op;
    if (pv[0] && pv[1]) winner = (last_m == 1) ? 0 : 1;
    else                winner = pv[1] ? 1 : 0;
    ok       = (po[winner] == 8'h52) || (po[winner] == 8'h57);
    done_ok  = ok && d >= 1 && d <= T;
    oh       = (winner == 1) ? 2'b10 : 2'b01;
    resp_k   = !ok ? 2 : (done_ok ? 2 + d : 2 + T);
    exp_err  = !done_ok;
    exp_addr = pa[winner];
    exp_op   = po[winner];
    req_valid   = {pv[1], pv[0]};
    req_addr[0] = pa[0]; req_addr[1] = pa[1];
    req_op[0]   = po[0]; req_op[1]   = po[1];
    eng_done    = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== oh || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL grant: req_ready=%b busy=%b, expected %b busy=0", req_ready, busy, oh);
    end
    for (int k = 1; k <= resp_k; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        pv[winner] = 1'b0;
        req_valid[winner] = 1'b0;
      end
      eng_done = done_ok && (k == 1 + d);
      @(negedge clk);
      n_cmp++;
      if (eng_valid !== (ok && k == 1) || rsp_valid !== ((k == resp_k) ? oh : 2'b00) ||
          busy !== 1'b1 || req_ready !== 2'b00) begin
        n_bad++;
        $display("FAIL cycle%0d: eng_valid=%b rsp_valid=%b busy=%b req_ready=%b, expected %b %b 1 00",
                 k, eng_valid, rsp_valid, busy, req_ready, ok && k == 1, (k == resp_k) ? oh : 2'b00);
      end
      if (ok) begin
        n_cmp++;
        if (eng_addr !== exp_addr || eng_op !== exp_op) begin
          n_bad++;
          $display("FAIL eng_latch: addr=%h op=%h, expected %h %h", eng_addr, eng_op, exp_addr, exp_op);
        end
      end
      if (k == resp_k) begin
        n_cmp++;
        if (rsp_err !== exp_err) begin
          n_bad++;
          $display("FAIL rsp_err: got %b, expected %b", rsp_err, exp_err);
        end
      end
    end
    @(posedge clk); #1;
    eng_done = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_rsp: busy=%b, expected 0", busy);
    end
    last_m = winner;
    gcnt_m[winner]++;
    if (ok && !done_ok) abort_m++;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if (req_ready !== 2'b00 || eng_valid !== 1'b0 || eng_addr !== '0 || eng_op !== '0 ||
        rsp_valid !== 2'b00 || rsp_err !== 1'b0 || proto_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: ready=%b ev=%b addr=%h op=%h rv=%b re=%b pe=%b busy=%b, expected all zero",
               tag, req_ready, eng_valid, eng_addr, eng_op, rsp_valid, rsp_err, proto_err, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 2'b11; eng_done = 1'b0;
    req_addr[0] = '0; req_addr[1] = '0; req_op[0] = '0; req_op[1] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_values");
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    int s0, s1;
    s0 = rsp_seen[0]; s1 = rsp_seen[1];
    for (int i = 0; i < 4; i++) begin
      if (!pv[0]) begin pv[0] = 1'b1; pa[0] = 48'hA000 + 48'(i); po[0] = 8'h52; end
      if (!pv[1]) begin pv[1] = 1'b1; pa[1] = 48'hB000 + 48'(i); po[1] = 8'h57; end
      do_txn(1 + i);
    end
    pv[0] = 1'b0; pv[1] = 1'b0; req_valid = 2'b00;
    n_cmp++;
    if (rsp_seen[0] - s0 != 2 || rsp_seen[1] - s1 != 2) begin
      n_bad++;
      $display("FAIL contention_rsp: req0=%0d req1=%0d pulses, expected 2 and 2",
               rsp_seen[0] - s0, rsp_seen[1] - s1);
    end
  endtask

  task automatic test_single_read();
    pv[0] = 1'b1; pa[0] = 48'h1000; po[0] = 8'h52;
    do_txn(2);
  endtask

  task automatic test_invalid_op();
    pv[1] = 1'b1; pa[1] = 48'h2222; po[1] = 8'h58;
    do_txn(1);
  endtask

  task automatic test_watchdog();
    pv[0] = 1'b1; pa[0] = 48'h3000; po[0] = 8'h57;
    do_txn(T + 5);
  endtask

  task automatic test_race_expiry();
    pv[1] = 1'b1; pa[1] = 48'h4000; po[1] = 8'h52;
    do_txn(T);
  endtask

  task automatic test_proto_err();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL proto_before: proto_err=%b, expected 0", proto_err);
    end
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL proto_set: proto_err=%b busy=%b, expected 1 0", proto_err, busy);
    end
    @(posedge clk); #1;
    pv[0] = 1'b1; pa[0] = 48'h5000; po[0] = 8'h52;
    do_txn(3);
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL proto_sticky: proto_err=%b, expected 1", proto_err);
    end
  endtask

  task automatic test_random();
    logic [63:0] r64;
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 1) == 1) begin
          r64 = {$urandom(), $urandom()};
          pv[r] = 1'b1;
          pa[r] = r64[AW-1:0];
          case ($urandom_range(0, 3))
            0: po[r] = 8'h52;
            1: po[r] = 8'h57;
            2: po[r] = 8'h58;
            default: po[r] = 8'($urandom());
          endcase
        end
      end
      if (!pv[0] && !pv[1]) begin
        pv[0] = 1'b1; pa[0] = 48'h6000 + 48'(i); po[0] = 8'h52;
      end
      do_txn($urandom_range(1, T + 2));
    end
    // Drain anything still pending so later tests start from an empty model.
    while (pv[0] || pv[1]) do_txn($urandom_range(1, T));
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_wait();
    pv[1] = 1'b1; pa[1] = 48'h7000; po[1] = 8'h52;
    req_valid = 2'b10; req_addr[1] = pa[1]; req_op[1] = po[1];
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_busy: busy=%b, expected 1", busy);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_values("mid_reset_values");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_quiet: rsp_valid=%b busy=%b, expected 00 0", rsp_valid, busy);
      end
    end
    @(posedge clk); #1;
    pv[0] = 1'b1; pa[0] = 48'h8000; po[0] = 8'h57;
    pv[1] = 1'b1; pa[1] = 48'h9000; po[1] = 8'h52;
    do_txn(2);
    do_txn(2);
    req_valid = 2'b00;
  endtask

  task automatic test_stats();
`ifdef CACHE_ARB_STATS_EN
    n_cmp++;
    if (grant_cnt0 !== 12'(gcnt_m[0]) || grant_cnt1 !== 12'(gcnt_m[1]) || abort_cnt !== 12'(abort_m)) begin
      n_bad++;
      $display("FAIL stats: g0=%0d g1=%0d ab=%0d, expected %0d %0d %0d",
               grant_cnt0, grant_cnt1, abort_cnt, gcnt_m[0], gcnt_m[1], abort_m);
    end
`endif
  endtask

  initial begin
    rsp_seen[0] = 0; rsp_seen[1] = 0;
    test_reset();
    test_contention();
    test_single_read();
    test_invalid_op();
    test_watchdog();
    test_race_expiry();
    test_proto_err();
    test_random();
    test_reset_mid_wait();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
